// File: rtl/galaksija_reset_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// galaksija_reset_seq
//
// Power-on / user reset sequencer for the Galaksija core running on the pixel
// clock. The core is released from reset only after the PLL has been stably
// locked and a fixed hold period has elapsed. A debounced user button re-runs
// the hold period, and losing PLL lock returns the sequencer to lock-waiting.
// The VGA output stage is enabled at the first vertical sync after the core
// starts running, so the display never starts mid-frame.
//
// Parameters:
//   LOCK_STABLE     - consecutive synchronized-lock cycles needed to leave
//                     WAIT_LOCK (>= 1)
//   HOLD_CYCLES     - number of clocks the core reset is held in HOLD (>= 1)
//   DEBOUNCE_CYCLES - button stability window in clocks (>= 1)
//   LED_DIV         - LED half-period in clocks, blink builds only (>= 1)
//
// Ports:
//   clk_i        in   pixel clock, all logic on its rising edge
//   rstn_i       in   asynchronous active-low reset
//   pll_locked_i in   PLL lock, asynchronous to clk_i
//   btn_n_i      in   raw user reset button, asynchronous, 0 = pressed
//   vsync_i      in   vertical sync from the core, active-high
//   reset_n_o    out  core reset, 0 = core held in reset
//   video_en_o   out  enable for the VGA output register stage
//   led_o        out  status LED
//   state_o      out  current state (00 WAIT_LOCK, 01 HOLD, 10 RUN)
//
// Build option:
//   GALAKSIJA_RESET_SEQ_LED_BLINK_EN - when defined, led_o blinks with period
//   2*LED_DIV in WAIT_LOCK, is 0 in HOLD and 1 in RUN. When undefined, led_o
//   simply mirrors reset_n_o and no blink counter exists.
// -----------------------------------------------------------------------------
module galaksija_reset_seq #(
    parameter int LOCK_STABLE     = 1024,
    parameter int HOLD_CYCLES     = 65536,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LED_DIV         = 6250000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       pll_locked_i,
    input  logic       btn_n_i,
    input  logic       vsync_i,
    output logic       reset_n_o,
    output logic       video_en_o,
    output logic       led_o,
    output logic [1:0] state_o
);

    // Parameter range checks, evaluated at elaboration time.
    if (LOCK_STABLE < 1) begin : g_bad_lock_stable
        $error("LOCK_STABLE must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("HOLD_CYCLES must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LED_DIV < 1) begin : g_bad_led_div
        $error("LED_DIV must be at least 1");
    end

    localparam int LOCK_W = $clog2(LOCK_STABLE + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    // Counters stop at "last" and act on it, so they never exceed param-1.
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_HOLD      = 2'b01,
        ST_RUN       = 2'b10,
        ST_ILLEGAL   = 2'b11
    } state_t;

    logic [1:0]        lock_sync_r;
    logic [1:0]        btn_sync_r;
    logic              locked_s;
    logic              btn_s;

    logic              btn_d_r;
    logic              btn_d_dly_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic              press_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [LOCK_W-1:0] lock_cnt_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;

    logic              vsync_q_r;
    logic              video_nxt_s;
    logic              reset_n_r;
    logic              video_en_r;

    // Two-flop synchronizers; the button idles released (1).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_sync_r <= 2'b00;
            btn_sync_r  <= 2'b11;
        end else begin
            lock_sync_r <= {lock_sync_r[0], pll_locked_i};
            btn_sync_r  <= {btn_sync_r[0], btn_n_i};
        end
    end

    assign locked_s = lock_sync_r[1];
    assign btn_s    = btn_sync_r[1];

    // Debouncer: btn_d follows btn_s only after a full window of disagreement.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            btn_d_r     <= 1'b1;
            btn_d_dly_r <= 1'b1;
            deb_cnt_r   <= '0;
        end else begin
            btn_d_dly_r <= btn_d_r;
            if (btn_s == btn_d_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r >= DEB_LAST) begin
                btn_d_r   <= btn_s;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end
    end

    // One-cycle press pulse on the debounced 1->0 transition.
    assign press_s = btn_d_dly_r & ~btn_d_r;

    // Next-state logic; counters default to 0 so any state change clears them.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = '0;
        hold_cnt_nxt_s = '0;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (!locked_s) begin
                    lock_cnt_nxt_s = '0;
                end else if (lock_cnt_r >= LOCK_LAST) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + LOCK_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (press_s) begin
                    hold_cnt_nxt_s = '0;
                end else if (hold_cnt_r >= HOLD_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss has priority over a simultaneous press.
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (press_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_LOCK;
            end
        endcase
    end

    // Video is armed by a vsync rising edge seen in RUN and held until RUN ends.
    always_comb begin
        video_nxt_s = 1'b0;
        if (state_nxt_s == ST_RUN) begin
            video_nxt_s = video_en_r | ((state_r == ST_RUN) & vsync_i & ~vsync_q_r);
        end else begin
            video_nxt_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= ST_WAIT_LOCK;
            lock_cnt_r <= '0;
            hold_cnt_r <= '0;
            vsync_q_r  <= 1'b0;
            reset_n_r  <= 1'b0;
            video_en_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            vsync_q_r  <= vsync_i;
            // Derived from next state so reset_n_o lines up with state_o.
            reset_n_r  <= (state_nxt_s == ST_RUN);
            video_en_r <= video_nxt_s;
        end
    end

    assign state_o    = state_r;
    assign reset_n_o  = reset_n_r;
    assign video_en_o = video_en_r;

`ifdef GALAKSIJA_RESET_SEQ_LED_BLINK_EN
    localparam int LED_W = $clog2(LED_DIV + 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_DIV - 1);

    logic [LED_W-1:0] blink_cnt_r;
    logic [LED_W-1:0] blink_cnt_nxt_s;
    logic             led_r;
    logic             led_nxt_s;

    // LED pattern: blink while waiting for lock, off in HOLD, on in RUN.
    always_comb begin
        blink_cnt_nxt_s = '0;
        led_nxt_s       = 1'b0;
        case (state_nxt_s)
            ST_WAIT_LOCK: begin
                if (state_r != ST_WAIT_LOCK) begin
                    blink_cnt_nxt_s = '0;
                    led_nxt_s       = 1'b0;
                end else if (blink_cnt_r >= LED_LAST) begin
                    blink_cnt_nxt_s = '0;
                    led_nxt_s       = ~led_r;
                end else begin
                    blink_cnt_nxt_s = blink_cnt_r + LED_W'(1);
                    led_nxt_s       = led_r;
                end
            end
            ST_HOLD: begin
                led_nxt_s = 1'b0;
            end
            ST_RUN: begin
                led_nxt_s = 1'b1;
            end
            default: begin
                led_nxt_s = 1'b0;
            end
        endcase
    end

    // Blink counter and LED register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            blink_cnt_r <= '0;
            led_r       <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            led_r       <= led_nxt_s;
        end
    end

    assign led_o = led_r;
`else
    assign led_o = reset_n_r;
`endif

endmodule

// File: tb/tb_galaksija_reset_seq.sv
`timescale 1ns/1ps
module tb_galaksija_reset_seq;

    localparam int LOCK_STABLE     = 4;
    localparam int HOLD_CYCLES     = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LED_DIV         = 3;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       pll_locked_i;
    logic       btn_n_i;
    logic       vsync_i;
    logic       reset_n_o;
    logic       video_en_o;
    logic       led_o;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk_i = ~clk_i;

    galaksija_reset_seq #(
        .LOCK_STABLE    (LOCK_STABLE),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LED_DIV        (LED_DIV)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .pll_locked_i(pll_locked_i),
        .btn_n_i     (btn_n_i),
        .vsync_i     (vsync_i),
        .reset_n_o   (reset_n_o),
        .video_en_o  (video_en_o),
        .led_o       (led_o),
        .state_o     (state_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 waiting for lock, 1 holding core reset, 2 running
    int m_mode, m_lock_run, m_hold_age, m_wait_age, m_disagree;
    bit m_lk0, m_lk1, m_bt0, m_bt1;
    bit m_btn_d, m_btn_d_old, m_vs_old, m_video, m_led;

    task automatic model_reset();
        m_mode = 0; m_lock_run = 0; m_hold_age = 0; m_wait_age = 0; m_disagree = 0;
        m_lk0 = 1'b0; m_lk1 = 1'b0; m_bt0 = 1'b1; m_bt1 = 1'b1;
        m_btn_d = 1'b1; m_btn_d_old = 1'b1; m_vs_old = 1'b0;
        m_video = 1'b0; m_led = 1'b0;
    endtask

    task automatic model_step();
        bit ls, bs, press, rise, new_btn_d;
        int prev, nxt;
        ls    = m_lk1;
        bs    = m_bt1;
        press = m_btn_d_old && !m_btn_d;
        rise  = vsync_i && !m_vs_old;
        prev  = m_mode;
        nxt   = prev;
        if (prev == 0) begin
            m_lock_run = ls ? m_lock_run + 1 : 0;
            if (m_lock_run >= LOCK_STABLE) nxt = 1;
        end else if (prev == 1) begin
            if (!ls) nxt = 0;
            else if (press) m_hold_age = 0;
            else begin
                m_hold_age++;
                if (m_hold_age >= HOLD_CYCLES) nxt = 2;
            end
        end else begin
            if (!ls) nxt = 0;
            else if (press) nxt = 1;
        end
        if (nxt != prev) begin
            m_lock_run = 0; m_hold_age = 0; m_wait_age = 0;
        end else if (nxt == 0) begin
            m_wait_age++;
        end
        m_video = (nxt == 2) && (m_video || (prev == 2 && rise));
`ifdef GALAKSIJA_RESET_SEQ_LED_BLINK_EN
        m_led = (nxt == 0) ? (((m_wait_age / LED_DIV) % 2) == 1) : (nxt == 2);
`else
        m_led = (nxt == 2);
`endif
        new_btn_d = m_btn_d;
        if (bs != m_btn_d) begin
            m_disagree++;
            if (m_disagree >= DEBOUNCE_CYCLES) begin
                new_btn_d  = bs;
                m_disagree = 0;
            end
        end else begin
            m_disagree = 0;
        end
        m_btn_d_old = m_btn_d;
        m_btn_d     = new_btn_d;
        m_lk1 = m_lk0; m_lk0 = pll_locked_i;
        m_bt1 = m_bt0; m_bt0 = btn_n_i;
        m_vs_old = vsync_i;
        m_mode = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                check("model state_o",    int'(state_o),    m_mode);
                check("model reset_n_o",  int'(reset_n_o),  (m_mode == 2) ? 1 : 0);
                check("model video_en_o", int'(video_en_o), int'(m_video));
                check("model led_o",      int'(led_o),      int'(m_led));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state_o"},    int'(state_o),    0);
        check({tag, " reset_n_o"},  int'(reset_n_o),  0);
        check({tag, " video_en_o"}, int'(video_en_o), 0);
        check({tag, " led_o"},      int'(led_o),      0);
    endtask

    initial begin
        int lock_low, btn_left, vs_left, budget;
        rstn_i = 1'b0; pll_locked_i = 1'b0; btn_n_i = 1'b1; vsync_i = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        check_reset_outputs("reset");

        // Lock from cycle 0: HOLD after 6 edges, RUN 8 edges later.
        rstn_i = 1'b1; pll_locked_i = 1'b1;
        repeat (5) step();
        check("lock wait before hold", int'(state_o), 0);
        step();
        check("hold entry", int'(state_o), 1);
        check("hold reset_n", int'(reset_n_o), 0);
        repeat (7) step();
        check("hold last cycle", int'(state_o), 1);
        step();
        check("run entry", int'(state_o), 2);
        check("run reset_n", int'(reset_n_o), 1);
        check("video before vsync", int'(video_en_o), 0);
        vsync_i = 1'b1;
        step();
        check("video after vsync rise", int'(video_en_o), 1);
        repeat (2) step();
        vsync_i = 1'b0;

        // Short (3-cycle) button press is filtered out.
        btn_n_i = 1'b0;
        repeat (3) step();
        btn_n_i = 1'b1;
        repeat (10) step();
        check("short press ignored", int'(state_o), 2);
        check("short press video", int'(video_en_o), 1);

        // Long press: HOLD after 7 edges, RUN again 8 edges later.
        btn_n_i = 1'b0;
        repeat (6) step();
        check("press pending", int'(state_o), 2);
        step();
        check("press hold", int'(state_o), 1);
        check("press reset_n", int'(reset_n_o), 0);
        check("press video", int'(video_en_o), 0);
        btn_n_i = 1'b1;
        repeat (7) step();
        check("press hold last", int'(state_o), 1);
        step();
        check("press rerun", int'(state_o), 2);

        // Lock drop and press event in the same RUN cycle: lock loss wins.
        btn_n_i = 1'b0;
        repeat (4) step();
        pll_locked_i = 1'b0;
        repeat (2) step();
        check("both pending", int'(state_o), 2);
        step();
        check("lock beats press", int'(state_o), 0);
        check("lock beats press reset_n", int'(reset_n_o), 0);
        btn_n_i = 1'b1; pll_locked_i = 1'b1;

        // Asynchronous reset in the middle of HOLD.
        budget = 0;
        while (state_o != 2'b01 && budget < 64) begin
            step();
            budget++;
        end
        check("reach hold within budget", (budget < 64) ? 1 : 0, 1);
        repeat (3) step();
        check("mid hold", int'(state_o), 1);
        #1;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) step();

        // One-cycle lock glitch at count 3 restarts the lock count.
        rstn_i = 1'b1; pll_locked_i = 1'b1;
        repeat (3) step();
        pll_locked_i = 1'b0;
        step();
        pll_locked_i = 1'b1;
        repeat (5) step();
        check("glitch still waiting", int'(state_o), 0);
        step();
        check("glitch then hold", int'(state_o), 1);

        // LED in WAIT_LOCK.
        rstn_i = 1'b0; pll_locked_i = 1'b0;
        repeat (2) step();
        rstn_i = 1'b1;
        repeat (3) step();
`ifdef GALAKSIJA_RESET_SEQ_LED_BLINK_EN
        check("blink first toggle", int'(led_o), 1);
        repeat (3) step();
        check("blink second toggle", int'(led_o), 0);
`else
        check("led tracks reset_n in wait", int'(led_o), 0);
        repeat (3) step();
        check("led still off in wait", int'(led_o), 0);
`endif

        // Randomized traffic against the model.
        lock_low = 0; btn_left = 0; vs_left = 0;
        pll_locked_i = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (lock_low > 0) begin
                lock_low--;
                pll_locked_i = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                lock_low = int'($urandom_range(1, 5));
                pll_locked_i = 1'b0;
            end else begin
                pll_locked_i = 1'b1;
            end
            if (btn_left > 0) begin
                btn_left--;
                btn_n_i = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                btn_left = int'($urandom_range(1, 9));
                btn_n_i = 1'b0;
            end else begin
                btn_n_i = 1'b1;
            end
            if (vs_left > 0) begin
                vs_left--;
            end else begin
                vsync_i = ~vsync_i;
                vs_left = int'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1499) == 0) begin
                #($urandom_range(1, 2));
                rstn_i = 1'b0;
                #1;
                check_reset_outputs("random async reset");
                repeat (2) step();
                rstn_i = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
